// File: rtl/module_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// module_spi_shift_engine
//
// SPI mode-0 (CPOL=0, CPHA=0) master shift engine. Accepts one word per start
// request from the upstream transmit-data select stage. It serialises the word
// on MOSI, generates SCLK and CS_N, and captures MISO in parallel. The received
// word is presented together with a one-cycle done pulse.
//
// Parameters:
//   DATA_WIDTH  - bits per transfer (>= 2)
//   HALF_PERIOD - system clocks per SCLK half-period (>= 1)
//
// Build option:
//   SPI_SHIFT_LSB_FIRST_EN - when defined, transmit LSB first, and receive by
//                            shifting right with the newest bit entering the
//                            MSB. Timing is identical to the default
//                            MSB-first build.
//
// Ports:
//   clk_i    in   system clock, rising edge
//   rst_i    in   synchronous active-high reset
//   start_i  in   transfer request, honoured only while idle
//   data_i   in   transmit word, latched on an accepted start
//   miso_i   in   serial data from the slave, sampled on SCLK rise
//   sclk_o   out  SPI clock, idles low
//   mosi_o   out  serial data to the slave, changes on SCLK fall
//   cs_n_o   out  active-low chip select
//   busy_o   out  transfer in progress
//   done_o   out  one-cycle pulse at transfer end
//   data_o   out  last received word, held until the next done_o
// -----------------------------------------------------------------------------
module module_spi_shift_engine #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  cs_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned HCW = $clog2(HALF_PERIOD + 1);

    localparam logic [HCW-1:0] HC_LAST = HCW'(HALF_PERIOD - 1);
    localparam logic [BCW-1:0] BC_FULL = BCW'(DATA_WIDTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    logic [2:0]            r_state;
    logic [HCW-1:0]        r_hcnt;
    logic [BCW-1:0]        r_bcnt;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_half_done;
    logic                  w_first_bit;
    logic                  w_next_bit;
    logic [DATA_WIDTH-1:0] w_tx_shifted;
    logic [DATA_WIDTH-1:0] w_rx_shifted;

    assign w_half_done = (r_hcnt == HC_LAST);

`ifdef SPI_SHIFT_LSB_FIRST_EN
    assign w_first_bit  = data_i[0];
    assign w_next_bit   = r_tx[1];
    assign w_tx_shifted = r_tx >> 1;
    assign w_rx_shifted = {miso_i, r_rx[DATA_WIDTH-1:1]};
`else
    assign w_first_bit  = data_i[DATA_WIDTH-1];
    assign w_next_bit   = r_tx[DATA_WIDTH-2];
    assign w_tx_shifted = r_tx << 1;
    assign w_rx_shifted = {r_rx[DATA_WIDTH-2:0], miso_i};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_hcnt <= '0;
                    r_bcnt <= '0;
                    if (start_i) begin
                        r_tx    <= data_i;
                        r_mosi  <= w_first_bit;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end else begin
                        r_mosi <= 1'b0;
                    end
                end
                // SETUP and LOW both end in a rising SCLK edge with a MISO sample.
                ST_SETUP, ST_LOW: begin
                    if (w_half_done) begin
                        r_hcnt  <= '0;
                        r_sclk  <= 1'b1;
                        r_rx    <= w_rx_shifted;
                        r_bcnt  <= r_bcnt + BCW'(1);
                        r_state <= ST_HIGH;
                    end else begin
                        r_hcnt <= r_hcnt + HCW'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_half_done) begin
                        r_hcnt <= '0;
                        r_sclk <= 1'b0;
                        if (r_bcnt < BC_FULL) begin
                            r_tx    <= w_tx_shifted;
                            r_mosi  <= w_next_bit;
                            r_state <= ST_LOW;
                        end else begin
                            // Last bit stays on MOSI through the CS hold time.
                            r_state <= ST_HOLD;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + HCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_half_done) begin
                        r_hcnt  <= '0;
                        r_cs_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_data  <= r_rx;
                        r_mosi  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + HCW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk_o = r_sclk;
    assign mosi_o = r_mosi;
    assign cs_n_o = r_cs_n;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign data_o = r_data;

endmodule

// File: tb/tb_module_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_module_spi_shift_engine
//
// Self-checking bench for module_spi_shift_engine. Expected waveforms are
// computed cycle by cycle from the transfer timing (offset from the accepting
// edge). The expected received word is built from the MISO bits that the bench
// presents at each SCLK rise.
// -----------------------------------------------------------------------------
module tb_module_spi_shift_engine;

    localparam int D   = 8;
    localparam int H   = 2;
    localparam int END = (2 * D + 1) * H;

    logic         clk_i;
    logic         rst_i;
    logic         start_i;
    logic [D-1:0] data_i;
    logic         miso_i;
    logic         sclk_o;
    logic         mosi_o;
    logic         cs_n_o;
    logic         busy_o;
    logic         done_o;
    logic [D-1:0] data_o;

    int           n_checks;
    int           n_errors;
    logic [D-1:0] exp_data;

    module_spi_shift_engine #(
        .DATA_WIDTH (D),
        .HALF_PERIOD(H)
    ) u_dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i),
        .data_i (data_i),
        .miso_i (miso_i),
        .sclk_o (sclk_o),
        .mosi_o (mosi_o),
        .cs_n_o (cs_n_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .data_o (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Bit placed on the wire for the j-th SCLK period.
    function automatic logic tx_bit(input logic [D-1:0] d, input int j);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        return d[j];
`else
        return d[D-1-j];
`endif
    endfunction

    // Received word, given the bit presented at each rise (index = rise number).
    function automatic logic [D-1:0] rx_word(input logic [D-1:0] pat);
        logic [D-1:0] w;
        for (int k = 0; k < D; k++) begin
`ifdef SPI_SHIFT_LSB_FIRST_EN
            w[k] = pat[k];
`else
            w[D-1-k] = pat[k];
`endif
        end
        return w;
    endfunction

    function automatic logic [D-1:0] loop_pat(input logic [D-1:0] d);
        logic [D-1:0] p;
        for (int k = 0; k < D; k++) p[k] = tx_bit(d, k);
        return p;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, ".sclk"}, 32'(sclk_o), 32'd0);
        check_eq({tag, ".mosi"}, 32'(mosi_o), 32'd0);
        check_eq({tag, ".cs_n"}, 32'(cs_n_o), 32'd1);
        check_eq({tag, ".busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, ".done"}, 32'(done_o), 32'd0);
        check_eq({tag, ".data"}, 32'(data_o), 32'(exp_data));
    endtask

    task automatic idle_cycles(input int n);
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check_idle($sformatf("idle%0d", i));
        end
    endtask

    // One full transfer. Returns #1 after the edge that raises done_o.
    task automatic xfer(input string name, input logic [D-1:0] d, input logic [D-1:0] pat,
                        input bit pulse_start, input bit hold_start);
        int           k;
        int           j;
        int           p;
        logic         exp_sclk;
        logic [D-1:0] exp_rx;
        exp_rx  = rx_word(pat);
        data_i  = d;
        start_i = 1'b1;
        miso_i  = pat[0];
        step();
        if (!hold_start) start_i = 1'b0;
        for (int t = 0; t < END; t++) begin
            p        = (t - H) / H;
            exp_sclk = (t >= H) && (p % 2 == 0) && (p < 2 * D);
            j        = t / (2 * H);
            if (j > D - 1) j = D - 1;
            check_eq($sformatf("%s.t%0d.sclk", name, t), 32'(sclk_o), 32'(exp_sclk));
            check_eq($sformatf("%s.t%0d.mosi", name, t), 32'(mosi_o), 32'(tx_bit(d, j)));
            check_eq($sformatf("%s.t%0d.cs_n", name, t), 32'(cs_n_o), 32'd0);
            check_eq($sformatf("%s.t%0d.busy", name, t), 32'(busy_o), 32'd1);
            check_eq($sformatf("%s.t%0d.done", name, t), 32'(done_o), 32'd0);
            check_eq($sformatf("%s.t%0d.data", name, t), 32'(data_o), 32'(exp_data));
            // Present the bit for the rise that may occur at the next edge.
            k = (t + 1) / (2 * H);
            if (k > D - 1) k = D - 1;
            miso_i = pat[k];
            data_i = D'($urandom);
            start_i = hold_start | (pulse_start & ((t + 1 == 5) || (t + 1 == 20)));
            step();
        end
        exp_data = exp_rx;
        check_eq({name, ".end.done"}, 32'(done_o), 32'd1);
        check_eq({name, ".end.busy"}, 32'(busy_o), 32'd0);
        check_eq({name, ".end.cs_n"}, 32'(cs_n_o), 32'd1);
        check_eq({name, ".end.sclk"}, 32'(sclk_o), 32'd0);
        check_eq({name, ".end.mosi"}, 32'(mosi_o), 32'd0);
        check_eq({name, ".end.data"}, 32'(data_o), 32'(exp_data));
    endtask

    initial begin
        logic [D-1:0] d;
        logic [D-1:0] pat;
        n_checks = 0;
        n_errors = 0;
        exp_data = '0;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        data_i   = '0;
        miso_i   = 1'b0;
        step();
        step();
        check_idle("reset");
        rst_i = 1'b0;
        idle_cycles(2);

        // Reset wins over a simultaneous start.
        rst_i   = 1'b1;
        start_i = 1'b1;
        data_i  = 8'hFF;
        step();
        check_idle("rst_start");
        rst_i = 1'b0;
        idle_cycles(2);

        xfer("loop_a5", 8'hA5, loop_pat(8'hA5), 1'b0, 1'b0);
        idle_cycles(2);
        xfer("fill00", 8'h00, 8'hFF, 1'b0, 1'b0);
        idle_cycles(1);
        xfer("dummyff", 8'hFF, 8'h00, 1'b0, 1'b0);
        idle_cycles(1);
        xfer("ignore", 8'h5A, loop_pat(8'h5A), 1'b1, 1'b0);
        idle_cycles(3);

        // Back-to-back with start held high: second accept on the edge after done.
        xfer("b2b_3c", 8'h3C, loop_pat(8'h3C), 1'b0, 1'b1);
        xfer("b2b_c3", 8'hC3, loop_pat(8'hC3), 1'b0, 1'b1);
        idle_cycles(2);

        // Reset at E+10 aborts the transfer without a done pulse.
        data_i  = 8'h96;
        start_i = 1'b1;
        miso_i  = 1'b1;
        step();
        start_i = 1'b0;
        for (int t = 0; t < 9; t++) step();
        rst_i = 1'b1;
        step();
        exp_data = '0;
        check_idle("midrst");
        rst_i = 1'b0;
        idle_cycles(END + 2);
        xfer("after_rst", 8'h69, loop_pat(8'h69), 1'b0, 1'b0);
        idle_cycles(1);

        xfer("lsb01", 8'h01, loop_pat(8'h01), 1'b0, 1'b0);
        idle_cycles(1);

        for (int i = 0; i < 12; i++) begin
            d   = D'($urandom);
            pat = ($urandom_range(0, 1) == 0) ? loop_pat(d) : D'($urandom);
            xfer($sformatf("rnd%0d", i), d, pat, ($urandom_range(0, 3) == 0), 1'b0);
            idle_cycles($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
